esm_dwell_reporter: RTL and testbench

//  Transmit side of the ESM report stream. Snoops esm_dwell_controller outputs (Dwell_active/Dwell_data/Dwell_sequence_num),

---
 rtl/esm_dwell_reporter_pkg.sv | 65 ++++++
 rtl/esm_dwell_reporter_if.sv | 10 +
 rtl/esm_dwell_reporter_serializer.sv | 76 +++++++
 rtl/esm_dwell_reporter.sv | 121 ++++++++++++
 tb/tb_esm_dwell_reporter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/esm_dwell_reporter_pkg.sv
// Shared types and constants for the ESM dwell report stream.
// The optional drop-count word is enabled by ESM_DWELL_REPORTER_DROP_COUNT_EN.
package esm_dwell_reporter_pkg;

    localparam int unsigned esm_report_idx_w = 5;
    localparam logic [31:0] esm_report_magic_num = 32'hE5D0_A7A5;
    localparam logic [7:0]  esm_module_id_dwell_reporter = 8'h0D;
    localparam logic [7:0]  esm_report_message_type_dwell_stats = 8'h02;

`ifdef ESM_DWELL_REPORTER_DROP_COUNT_EN
    localparam int unsigned esm_dwell_report_words = 17;
`else
    localparam int unsigned esm_dwell_report_words = 16;
`endif

    typedef struct packed {
        logic [15:0] tag;
        logic [15:0] frequency;
        logic [31:0] duration;
        logic [7:0]  gain;
        logic [7:0]  fast_lock_profile;
        logic [31:0] threshold_narrow;
        logic [31:0] threshold_wide;
        logic [63:0] channel_mask_narrow;
        logic [7:0]  channel_mask_wide;
    } esm_dwell_metadata_t;

    typedef struct packed {
        esm_dwell_metadata_t metadata;
        logic [31:0]         dwell_seq;
        logic [63:0]         ts_start;
        logic [63:0]         ts_end;
    } esm_dwell_report_t;

    typedef enum logic {CAP_IDLE, CAP_ACTIVE} esm_cap_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} esm_tx_state_t;

    // Fixed part of the report; words beyond 15 are supplied by the caller.
    function automatic logic [31:0] esm_dwell_report_word(
        input esm_dwell_report_t           rep,
        input logic [31:0]                 report_seq,
        input logic [esm_report_idx_w-1:0] idx
    );
        case (idx)
            5'd0:    return esm_report_magic_num;
            5'd1:    return report_seq;
            5'd2:    return {esm_module_id_dwell_reporter, esm_report_message_type_dwell_stats, 16'h0};
            5'd3:    return rep.dwell_seq;
            5'd4:    return {rep.metadata.frequency, rep.metadata.tag};
            5'd5:    return rep.metadata.duration;
            5'd6:    return {16'h0, rep.metadata.fast_lock_profile, rep.metadata.gain};
            5'd7:    return rep.metadata.threshold_narrow;
            5'd8:    return rep.metadata.threshold_wide;
            5'd9:    return rep.metadata.channel_mask_narrow[31:0];
            5'd10:   return rep.metadata.channel_mask_narrow[63:32];
            5'd11:   return {24'h0, rep.metadata.channel_mask_wide};
            5'd12:   return rep.ts_start[31:0];
            5'd13:   return rep.ts_start[63:32];
            5'd14:   return rep.ts_end[31:0];
            5'd15:   return rep.ts_end[63:32];
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/esm_dwell_reporter_if.sv
// 32-bit AXI-stream report channel between the dwell reporter and the DMA.
interface esm_dwell_reporter_if;
    logic        Axis_valid;
    logic        Axis_ready;
    logic [31:0] Axis_data;
    logic        Axis_last;

    modport master (output Axis_valid, output Axis_data, output Axis_last, input Axis_ready);
    modport slave  (input Axis_valid, input Axis_data, input Axis_last, output Axis_ready);
endinterface

// File: rtl/esm_dwell_reporter_serializer.sv
// Walks one captured dwell report out as an AXI-stream message, one word per accept.
// Appends the drop-count word when ESM_DWELL_REPORTER_DROP_COUNT_EN is defined.
module esm_dwell_reporter_serializer
    import esm_dwell_reporter_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_load,
    input  esm_dwell_report_t i_report,
    input  logic [31:0]       i_report_seq,
`ifdef ESM_DWELL_REPORTER_DROP_COUNT_EN
    input  logic [31:0]       i_drop_count,
`endif
    output logic              o_can_load_c,
    output logic              o_done_c,
    esm_dwell_reporter_if.master Axis
);

    localparam logic [esm_report_idx_w-1:0] LAST_IDX = esm_report_idx_w'(esm_dwell_report_words - 1);

    esm_tx_state_t                r_state;
    logic [esm_report_idx_w-1:0]  r_idx;
    esm_dwell_report_t            r_report;
    logic [31:0]                  r_report_seq;

    logic                         w_accept;
    logic [esm_report_idx_w-1:0]  w_next_idx;
    logic [31:0]                  w_next_word;

    // A new report may load in the same cycle the previous last word is taken.
    always_comb begin
        w_accept     = (r_state == TX_SEND) && Axis.Axis_ready;
        o_done_c     = w_accept && (r_idx == LAST_IDX);
        o_can_load_c = (r_state == TX_IDLE) || o_done_c;
        w_next_idx   = r_idx + esm_report_idx_w'(1);
        w_next_word  = esm_dwell_report_word(r_report, r_report_seq, w_next_idx);
`ifdef ESM_DWELL_REPORTER_DROP_COUNT_EN
        if (w_next_idx == esm_report_idx_w'(16)) begin
            w_next_word = i_drop_count;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state         <= TX_IDLE;
            r_idx           <= '0;
            r_report        <= '0;
            r_report_seq    <= '0;
            Axis.Axis_valid <= 1'b0;
            Axis.Axis_data  <= '0;
            Axis.Axis_last  <= 1'b0;
        end else if (i_load) begin
            r_state         <= TX_SEND;
            r_idx           <= '0;
            r_report        <= i_report;
            r_report_seq    <= i_report_seq;
            Axis.Axis_valid <= 1'b1;
            Axis.Axis_data  <= esm_report_magic_num;
            Axis.Axis_last  <= 1'b0;
        end else if (w_accept) begin
            if (r_idx == LAST_IDX) begin
                r_state         <= TX_IDLE;
                r_idx           <= '0;
                Axis.Axis_valid <= 1'b0;
                Axis.Axis_data  <= '0;
                Axis.Axis_last  <= 1'b0;
            end else begin
                r_idx           <= w_next_idx;
                Axis.Axis_data  <= w_next_word;
                Axis.Axis_last  <= (w_next_idx == LAST_IDX);
            end
        end
    end

endmodule

// File: rtl/esm_dwell_reporter.sv
// Captures each dwell's metadata and timestamps and streams a fixed-length report per dwell.
// ESM_DWELL_REPORTER_DROP_COUNT_EN adds a saturating drop counter reported as the final word.
module esm_dwell_reporter
    import esm_dwell_reporter_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Enable,
    input  logic [63:0]         Timestamp,
    input  logic                Dwell_active,
    input  esm_dwell_metadata_t Dwell_data,
    input  logic [31:0]         Dwell_sequence_num,
    esm_dwell_reporter_if.master Axis
);

    if (AXI_DATA_WIDTH != 32) begin : g_width_check
        $error("esm_dwell_reporter: only AXI_DATA_WIDTH=32 is supported");
    end

    esm_cap_state_t      r_cap_state;
    logic                r_prev_active;
    esm_dwell_metadata_t r_cap_meta;
    logic [31:0]         r_cap_seq;
    logic [63:0]         r_cap_ts_start;
    logic                r_pending;
    esm_dwell_report_t   r_slot;
    logic [31:0]         r_report_seq;

    logic                w_push;
    logic                w_load;
    logic                w_can_load;
    logic                w_done;
    logic [31:0]         w_load_seq;

    // The report sequence number must already reflect a report finishing this cycle.
    always_comb begin
        w_push     = (r_cap_state == CAP_ACTIVE) && !Dwell_active;
        w_load     = r_pending && w_can_load;
        w_load_seq = w_done ? (r_report_seq + 32'd1) : r_report_seq;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cap_state    <= CAP_IDLE;
            r_prev_active  <= 1'b0;
            r_cap_meta     <= '0;
            r_cap_seq      <= '0;
            r_cap_ts_start <= '0;
        end else begin
            r_prev_active <= Dwell_active;
            case (r_cap_state)
                CAP_IDLE: begin
                    if (Dwell_active && !r_prev_active && Enable) begin
                        r_cap_meta     <= Dwell_data;
                        r_cap_seq      <= Dwell_sequence_num;
                        r_cap_ts_start <= Timestamp;
                        r_cap_state    <= CAP_ACTIVE;
                    end
                end
                CAP_ACTIVE: begin
                    if (!Dwell_active) begin
                        r_cap_state <= CAP_IDLE;
                    end
                end
                default: r_cap_state <= CAP_IDLE;
            endcase
        end
    end

    // Single-entry pending slot; a slot being drained this cycle accepts the push.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pending    <= 1'b0;
            r_slot       <= '0;
            r_report_seq <= '0;
        end else begin
            if (w_push && (!r_pending || w_load)) begin
                r_slot    <= '{metadata: r_cap_meta, dwell_seq: r_cap_seq,
                               ts_start: r_cap_ts_start, ts_end: Timestamp};
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
            if (w_done) begin
                r_report_seq <= r_report_seq + 32'd1;
            end
        end
    end

`ifdef ESM_DWELL_REPORTER_DROP_COUNT_EN
    logic        w_drop;
    logic [31:0] r_drop_count;

    assign w_drop = w_push && r_pending && !w_load;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 32'hFFFF_FFFF)) begin
            r_drop_count <= r_drop_count + 32'd1;
        end
    end
`endif

    esm_dwell_reporter_serializer u_serializer (
        .Clk          (Clk),
        .Rst          (Rst),
        .i_load       (w_load),
        .i_report     (r_slot),
        .i_report_seq (w_load_seq),
`ifdef ESM_DWELL_REPORTER_DROP_COUNT_EN
        .i_drop_count (r_drop_count),
`endif
        .o_can_load_c (w_can_load),
        .o_done_c     (w_done),
        .Axis         (Axis)
    );

endmodule

// File: tb/tb_esm_dwell_reporter.sv
// Directed self-checking bench for esm_dwell_reporter (either setting of ESM_DWELL_REPORTER_DROP_COUNT_EN).
`timescale 1ns/1ps
module tb_esm_dwell_reporter;
    import esm_dwell_reporter_pkg::*;

    localparam int NW = int'(esm_dwell_report_words);

    typedef struct {
        esm_dwell_metadata_t meta;
        logic [31:0]         dseq;
        logic [31:0]         rseq;
        logic [63:0]         ts_s;
        logic [63:0]         ts_e;
        logic [31:0]         drop;
    } exp_t;

    logic                Clk = 1'b0;
    logic                Rst;
    logic                Enable;
    logic                Dwell_active;
    logic [63:0]         ts = 64'd0;
    esm_dwell_metadata_t dd;
    logic [31:0]         dseq;
    esm_dwell_reporter_if axis_if();

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        rdy_mode = 1'b0;
    logic        rdy_fixed = 1'b1;
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_c[$];
    int          unstable = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] pd;
    logic        pl;
    logic [31:0] exp_rseq = 32'd0;
    logic [31:0] exp_drop = 32'd0;
    exp_t        expq[$];

    esm_dwell_reporter #(.AXI_DATA_WIDTH(32)) dut (
        .Clk                (Clk),
        .Rst                (Rst),
        .Enable             (Enable),
        .Timestamp          (ts),
        .Dwell_active       (Dwell_active),
        .Dwell_data         (dd),
        .Dwell_sequence_num (dseq),
        .Axis               (axis_if)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        ts  <= ts + 64'd1;
        cyc <= cyc + 1;
    end

    always @(posedge Clk) begin
        #1;
        axis_if.Axis_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Collects accepted words and counts stalled words that changed.
    always @(negedge Clk) begin
        if (Rst !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (axis_if.Axis_valid !== 1'b1 || axis_if.Axis_data !== pd || axis_if.Axis_last !== pl))
                unstable++;
            if (axis_if.Axis_valid === 1'b1 && axis_if.Axis_ready === 1'b1) begin
                got_d.push_back(axis_if.Axis_data);
                got_l.push_back(axis_if.Axis_last);
                got_c.push_back(cyc);
            end
            prev_stall = (axis_if.Axis_valid === 1'b1) && (axis_if.Axis_ready !== 1'b1);
            pd = axis_if.Axis_data;
            pl = axis_if.Axis_last;
        end
    end

    function automatic logic [31:0] expw(input exp_t e, input int w);
        case (w)
            0:  return 32'hE5D0_A7A5;
            1:  return e.rseq;
            2:  return 32'h0D02_0000;
            3:  return e.dseq;
            4:  return {e.meta.frequency, e.meta.tag};
            5:  return e.meta.duration;
            6:  return {16'h0, e.meta.fast_lock_profile, e.meta.gain};
            7:  return e.meta.threshold_narrow;
            8:  return e.meta.threshold_wide;
            9:  return e.meta.channel_mask_narrow[31:0];
            10: return e.meta.channel_mask_narrow[63:32];
            11: return {24'h0, e.meta.channel_mask_wide};
            12: return e.ts_s[31:0];
            13: return e.ts_s[63:32];
            14: return e.ts_e[31:0];
            15: return e.ts_e[63:32];
            16: return e.drop;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic esm_dwell_metadata_t rand_meta();
        esm_dwell_metadata_t m;
        m.tag                 = 16'($urandom);
        m.frequency           = 16'($urandom);
        m.duration            = $urandom;
        m.gain                = 8'($urandom);
        m.fast_lock_profile   = 8'($urandom);
        m.threshold_narrow    = $urandom;
        m.threshold_wide      = $urandom;
        m.channel_mask_narrow = {$urandom, $urandom};
        m.channel_mask_wide   = 8'($urandom);
        return m;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_got();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget && got_d.size() < n; i++) tick();
    endtask

    task automatic do_dwell(input esm_dwell_metadata_t m, input logic [31:0] s, input int len,
                            output logic [63:0] ts_s, output logic [63:0] ts_e);
        Dwell_active = 1'b1;
        dd   = m;
        dseq = s;
        ts_s = ts;
        repeat (len) tick();
        Dwell_active = 1'b0;
        ts_e = ts;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) tick();
        total++;
        if (axis_if.Axis_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", axis_if.Axis_valid); end
        total++;
        if (axis_if.Axis_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%0b exp=0", axis_if.Axis_last); end
        total++;
        if (axis_if.Axis_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", axis_if.Axis_data); end
        Rst = 1'b0;
        exp_rseq = 32'd0;
        exp_drop = 32'd0;
        repeat (2) tick();
    endtask

    task automatic test_single();
        exp_t ex;
        logic [63:0] s, e;
        rdy_fixed = 1'b1;
        clear_got();
        for (int i = 0; i < 2000 && ts != 64'd1000; i++) tick();
        total++;
        if (ts !== 64'd1000) begin bad++; $display("FAIL single_ts_wait got=%0d exp=1000", ts); end
        ex.meta = rand_meta();
        do_dwell(ex.meta, 32'd7, 250, s, e);
        ex.dseq = 32'd7; ex.rseq = exp_rseq; ex.ts_s = 64'd1000; ex.ts_e = 64'd1250; ex.drop = exp_drop;
        @(negedge Clk);
        @(negedge Clk);
        total++;
        if (axis_if.Axis_valid !== 1'b0) begin bad++; $display("FAIL single_lat_k1 got=%0b exp=0", axis_if.Axis_valid); end
        @(negedge Clk);
        total++;
        if (axis_if.Axis_valid !== 1'b1) begin bad++; $display("FAIL single_lat_k2 got=%0b exp=1", axis_if.Axis_valid); end
        wait_words(NW, 100);
        total++;
        if (got_d.size() != NW) begin bad++; $display("FAIL single_count got=%0d exp=%0d", got_d.size(), NW); end
        for (int i = 0; i < NW && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== expw(ex, i) || got_l[i] !== 1'(i == NW - 1)) begin
                bad++;
                $display("FAIL single_w%0d got=%h/%0b exp=%h/%0b", i, got_d[i], got_l[i], expw(ex, i), i == NW - 1);
            end
        end
        exp_rseq++;
    endtask

    task automatic test_enable();
        exp_t ex;
        rdy_fixed = 1'b1;
        clear_got();
        Enable = 1'b0;
        Dwell_active = 1'b1; dd = rand_meta(); dseq = 32'd55;
        repeat (2) tick();
        Enable = 1'b1;
        repeat (2) tick();
        Dwell_active = 1'b0;
        repeat (40) tick();
        total++;
        if (got_d.size() != 0) begin bad++; $display("FAIL enable_off_start got=%0d words exp=0", got_d.size()); end
        ex.meta = rand_meta(); ex.dseq = 32'd56; ex.rseq = exp_rseq; ex.drop = exp_drop;
        Dwell_active = 1'b1; dd = ex.meta; dseq = ex.dseq; ex.ts_s = ts;
        repeat (2) tick();
        Enable = 1'b0;
        repeat (2) tick();
        Dwell_active = 1'b0; ex.ts_e = ts;
        wait_words(NW, 100);
        Enable = 1'b1;
        total++;
        if (got_d.size() != NW) begin bad++; $display("FAIL enable_mid_count got=%0d exp=%0d", got_d.size(), NW); end
        for (int i = 0; i < NW && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== expw(ex, i) || got_l[i] !== 1'(i == NW - 1)) begin
                bad++;
                $display("FAIL enable_w%0d got=%h/%0b exp=%h/%0b", i, got_d[i], got_l[i], expw(ex, i), i == NW - 1);
            end
        end
        exp_rseq++;
        tick();
    endtask

    task automatic test_stall_drop();
        exp_t ex[3];
        rdy_fixed = 1'b0;
        repeat (2) tick();
        clear_got();
        for (int k = 0; k < 3; k++) begin
            ex[k].meta = rand_meta();
            ex[k].dseq = 32'(100 + k);
            do_dwell(ex[k].meta, ex[k].dseq, 3, ex[k].ts_s, ex[k].ts_e);
            repeat (3) tick();
        end
        repeat (2) tick();
        total++;
        if (axis_if.Axis_valid !== 1'b1 || axis_if.Axis_data !== 32'hE5D0_A7A5) begin
            bad++; $display("FAIL stall_hold got=%0b/%h exp=1/e5d0a7a5", axis_if.Axis_valid, axis_if.Axis_data);
        end
        exp_drop = 32'd1;
        ex[0].rseq = exp_rseq; ex[1].rseq = exp_rseq + 32'd1;
        ex[0].drop = exp_drop; ex[1].drop = exp_drop;
        rdy_fixed = 1'b1;
        wait_words(2 * NW, 200);
        repeat (40) tick();
        total++;
        if (got_d.size() != 2 * NW) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", got_d.size(), 2 * NW); end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NW && r * NW + i < got_d.size(); i++) begin
                total++;
                if (got_d[r*NW+i] !== expw(ex[r], i) || got_l[r*NW+i] !== 1'(i == NW - 1)) begin
                    bad++;
                    $display("FAIL stall_r%0d_w%0d got=%h/%0b exp=%h/%0b", r, i, got_d[r*NW+i], got_l[r*NW+i], expw(ex[r], i), i == NW - 1);
                end
            end
        end
        exp_rseq += 32'd2;
    endtask

    task automatic test_back_to_back();
        exp_t ex[4];
        int maxgap;
        rdy_fixed = 1'b1;
        clear_got();
        for (int k = 0; k < 4; k++) begin
            ex[k].meta = rand_meta();
            ex[k].dseq = 32'(200 + k);
            ex[k].rseq = exp_rseq + 32'(k);
            ex[k].drop = exp_drop;
            do_dwell(ex[k].meta, ex[k].dseq, 1, ex[k].ts_s, ex[k].ts_e);
            repeat (NW - 1) tick();
        end
        wait_words(4 * NW, 200);
        repeat (30) tick();
        total++;
        if (got_d.size() != 4 * NW) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_d.size(), 4 * NW); end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NW && r * NW + i < got_d.size(); i++) begin
                total++;
                if (got_d[r*NW+i] !== expw(ex[r], i) || got_l[r*NW+i] !== 1'(i == NW - 1)) begin
                    bad++;
                    $display("FAIL b2b_r%0d_w%0d got=%h/%0b exp=%h/%0b", r, i, got_d[r*NW+i], got_l[r*NW+i], expw(ex[r], i), i == NW - 1);
                end
            end
        end
        maxgap = 0;
        for (int i = 1; i < got_c.size(); i++)
            if (got_c[i] - got_c[i-1] > maxgap) maxgap = got_c[i] - got_c[i-1];
        total++;
        if (maxgap > 2) begin bad++; $display("FAIL b2b_gap got=%0d cycles exp<=2", maxgap); end
        exp_rseq += 32'd4;
    endtask

    task automatic test_reset_mid();
        exp_t ex;
        logic [63:0] s, e;
        rdy_fixed = 1'b1;
        clear_got();
        do_dwell(rand_meta(), 32'd300, 4, s, e);
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk);
            #2;
            if (got_d.size() >= 5) break;
        end
        Rst = 1'b1;
        #1;
        total++;
        if (axis_if.Axis_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b exp=0", axis_if.Axis_valid); end
        total++;
        if (axis_if.Axis_last !== 1'b0) begin bad++; $display("FAIL rstmid_last got=%0b exp=0", axis_if.Axis_last); end
        repeat (2) tick();
        Rst = 1'b0;
        exp_rseq = 32'd0;
        exp_drop = 32'd0;
        clear_got();
        repeat (3) tick();
        ex.meta = rand_meta(); ex.dseq = 32'd301; ex.rseq = 32'd0; ex.drop = 32'd0;
        do_dwell(ex.meta, ex.dseq, 2, ex.ts_s, ex.ts_e);
        wait_words(NW, 100);
        total++;
        if (got_d.size() != NW) begin bad++; $display("FAIL rstmid_count got=%0d exp=%0d", got_d.size(), NW); end
        for (int i = 0; i < NW && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== expw(ex, i) || got_l[i] !== 1'(i == NW - 1)) begin
                bad++;
                $display("FAIL rstmid_w%0d got=%h/%0b exp=%h/%0b", i, got_d[i], got_l[i], expw(ex, i), i == NW - 1);
            end
        end
        exp_rseq = 32'd1;
    endtask

    task automatic test_random_ready();
        exp_t ex;
        Rst = 1'b1;
        repeat (2) tick();
        Rst = 1'b0;
        exp_rseq = 32'd0;
        exp_drop = 32'd0;
        expq.delete();
        clear_got();
        tick();
        unstable = 0;
        rdy_mode = 1'b1;
        for (int k = 0; k < 200; k++) begin
            ex.meta = rand_meta();
            ex.dseq = $urandom;
            ex.rseq = exp_rseq;
            ex.drop = exp_drop;
            do_dwell(ex.meta, ex.dseq, $urandom_range(1, 4), ex.ts_s, ex.ts_e);
            expq.push_back(ex);
            exp_rseq++;
            tick();
            wait_words((k + 1) * NW, 300);
        end
        rdy_mode = 1'b0;
        repeat (5) tick();
        total++;
        if (got_d.size() != 200 * NW) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_d.size(), 200 * NW); end
        total++;
        if (unstable != 0) begin bad++; $display("FAIL rand_stall_stable got=%0d changes exp=0", unstable); end
        for (int r = 0; r < expq.size(); r++) begin
            for (int i = 0; i < NW && r * NW + i < got_d.size(); i++) begin
                total++;
                if (got_d[r*NW+i] !== expw(expq[r], i) || got_l[r*NW+i] !== 1'(i == NW - 1)) begin
                    bad++;
                    $display("FAIL rand_r%0d_w%0d got=%h/%0b exp=%h/%0b", r, i, got_d[r*NW+i], got_l[r*NW+i], expw(expq[r], i), i == NW - 1);
                end
            end
        end
    endtask

    initial begin
        Rst = 1'b1;
        Enable = 1'b1;
        Dwell_active = 1'b0;
        dd = '0;
        dseq = 32'd0;
        test_reset();
        test_single();
        test_enable();
        test_stall_drop();
        test_back_to_back();
        test_reset_mid();
        test_random_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
